// File: rtl/result_packer.sv
// Packs pairs of 16-bit engine results into 32-bit FIFO words, with a small holding queue and
// pad/flush at layer end. Define RESULT_PACK_STATS_EN to build word_count and overflow.
module result_packer #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned OUT_W       = 2 * DATA_W,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  input  logic              fifo_full,
  output logic              out_wr_en,
  output logic [OUT_W-1:0]  out_data,
  output logic              busy,
  output logic              flush_done,
  output logic [CNT_W-1:0]  word_count,
  output logic              overflow
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);

  typedef enum logic {StIdle, StFlush} state_e;

  state_e              state_q;
  logic                held_q, held_d;
  logic [DATA_W-1:0]   held_data_q, held_data_d;
  logic [OUT_W-1:0]    mem [QUEUE_DEPTH];
  logic [PTR_W:0]      wr_ptr_q, rd_ptr_q;
  logic                q_empty, q_full, pop, push, push_ok, drop;
  logic [OUT_W-1:0]    push_word;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign q_empty = (wr_ptr_q == rd_ptr_q);
  assign q_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop     = !q_empty && !fifo_full;
  assign drop    = push && q_full && !pop;
  assign push_ok = push && !drop;

  always_comb begin
    push        = 1'b0;
    push_word   = '0;
    held_d      = held_q;
    held_data_d = held_data_q;
    if (state_q == StIdle) begin
      if (in_valid) begin
        if (held_q) begin
          push      = 1'b1;
          push_word = {in_data, held_data_q};
          held_d    = 1'b0;
        end else begin
          held_d      = 1'b1;
          held_data_d = in_data;
        end
      end
      // Sample on the flush cycle is taken first; any leftover half is padded out.
      if (flush && held_d) begin
        push      = 1'b1;
        push_word = {{DATA_W{1'b0}}, held_data_d};
        held_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q[PTR_W-1:0]] <= push_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      held_q      <= 1'b0;
      held_data_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_wr_en   <= 1'b0;
      out_data    <= '0;
      flush_done  <= 1'b0;
    end else begin
      held_q      <= held_d;
      held_data_q <= held_data_d;
      flush_done  <= 1'b0;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      out_wr_en <= pop;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        out_data <= mem[rd_ptr_q[PTR_W-1:0]];
      end
      case (state_q)
        StIdle: begin
          if (flush) state_q <= StFlush;
        end
        StFlush: begin
          if (q_empty && !out_wr_en) begin
            state_q    <= StIdle;
            flush_done <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = held_q | !q_empty | out_wr_en | (state_q == StFlush);

`ifdef RESULT_PACK_STATS_EN
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (pop && (count_q != {CNT_W{1'b1}})) count_q <= count_q + 1'b1;
      if (drop || ((state_q == StFlush) && in_valid)) ovf_q <= 1'b1;
    end
  end

  assign word_count = count_q;
  assign overflow   = ovf_q;
`else
  assign word_count = '0;
  assign overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_result_packer.sv
// Self-checking bench for result_packer: queue-level reference model, directed and random stimulus.
module tb_result_packer;

  localparam int QD = 4;
`ifdef RESULT_PACK_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        flush = 1'b0;
  logic        fifo_full = 1'b0;
  logic        out_wr_en;
  logic [31:0] out_data;
  logic        busy;
  logic        flush_done;
  logic [15:0] word_count;
  logic        overflow;

  result_packer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .flush      (flush),
    .fifo_full  (fifo_full),
    .out_wr_en  (out_wr_en),
    .out_data   (out_data),
    .busy       (busy),
    .flush_done (flush_done),
    .word_count (word_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: words in flight are a plain queue; state is just "held half" and "flushing".
  bit          m_held, m_flushing, m_wr, m_done, m_ovf;
  logic [15:0] m_hs;
  logic [31:0] m_data;
  logic [31:0] m_q[$];
  int unsigned m_cnt;

  task automatic model_reset();
    m_held = 0; m_flushing = 0; m_wr = 0; m_done = 0; m_ovf = 0;
    m_hs = '0; m_data = '0; m_cnt = 0;
    m_q.delete();
  endtask

  task automatic model_step();
    bit          was_flushing, was_empty, was_wr, pop, have;
    logic [31:0] pw, w;
    was_flushing = m_flushing;
    was_empty    = (m_q.size() == 0);
    was_wr       = m_wr;
    pop          = !was_empty && !fifo_full;
    have         = 0;
    pw           = '0;
    w            = '0;
    if (!was_flushing) begin
      if (in_valid) begin
        if (m_held) begin
          have = 1; pw = {in_data, m_hs}; m_held = 0;
        end else begin
          m_held = 1; m_hs = in_data;
        end
      end
      if (flush) begin
        if (m_held) begin
          have = 1; pw = {16'h0000, m_hs}; m_held = 0;
        end
        m_flushing = 1;
      end
    end else if (in_valid) begin
      m_ovf = 1;
    end
    if (pop) w = m_q.pop_front();
    if (have) begin
      if (m_q.size() >= QD) m_ovf = 1;
      else m_q.push_back(pw);
    end
    m_wr = pop;
    if (pop) begin
      m_data = w;
      if (m_cnt < 65535) m_cnt++;
    end
    m_done = was_flushing && was_empty && !was_wr;
    if (m_done) m_flushing = 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  logic [31:0] wlog[$];
  int          wcyc[$];
  int          done_cnt = 0;

  initial begin
    @(negedge clk);
    forever begin
      chk("out_wr_en", {31'd0, out_wr_en}, {31'd0, m_wr});
      chk("out_data", out_data, m_data);
      chk("busy", {31'd0, busy},
          {31'd0, m_held | (m_q.size() != 0) | m_wr | m_flushing});
      chk("flush_done", {31'd0, flush_done}, {31'd0, m_done});
      chk("word_count", {16'd0, word_count}, Stats ? m_cnt : 32'd0);
      chk("overflow", {31'd0, overflow}, {31'd0, Stats & m_ovf});
      if (out_wr_en === 1'b1) begin
        wlog.push_back(out_data);
        wcyc.push_back(cyc);
      end
      if (flush_done === 1'b1) done_cnt++;
      @(negedge clk);
    end
  end

  task automatic drive(input bit v, input logic [15:0] d, input bit f);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    flush    = f;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 16'h0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 0; flush = 0;
    #2 rst = 1;
    #1;
    chk("rst_wr_en", {31'd0, out_wr_en}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, flush_done}, 32'd0);
    chk("rst_count", {16'd0, word_count}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    #2 rst = 0;
    @(negedge clk);
    wlog.delete(); wcyc.delete(); done_cnt = 0;
  endtask

  initial begin
    int t0;
    int seen;
    #1 rst = 1;
    do_reset();

    // Single pair, latency and lane order
    drive(1, 16'h1111, 0);
    drive(1, 16'h2222, 0);
    t0 = cyc;
    idle(6);
    chk("t1_nwords", wlog.size(), 1);
    if (wlog.size() == 1) begin
      chk("t1_word", wlog[0], 32'h2222_1111);
      chk("t1_latency", wcyc[0], t0 + 2);
    end
    chk("t1_count", {16'd0, word_count}, Stats ? 32'd1 : 32'd0);

    // Odd trailing sample padded on flush
    do_reset();
    drive(1, 16'h000A, 0);
    drive(1, 16'h000B, 0);
    drive(1, 16'h000C, 0);
    drive(0, 16'h0, 1);
    idle(8);
    chk("t2_nwords", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("t2_word0", wlog[0], 32'h000B_000A);
      chk("t2_word1", wlog[1], 32'h0000_000C);
    end
    chk("t2_done", done_cnt, 1);
    chk("t2_busy", {31'd0, busy}, 32'd0);

    // Back-pressure filling queue exactly, then drain
    do_reset();
    fifo_full = 1;
    for (int i = 0; i < 8; i++) drive(1, 16'h1000 + 16'(i), 0);
    idle(3);
    chk("t3_nowrite", wlog.size(), 0);
    chk("t3_ovf", {31'd0, overflow}, 32'd0);
    fifo_full = 0;
    idle(8);
    chk("t3_nwords", wlog.size(), 4);
    if (wlog.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("t3_word", wlog[k], {16'h1000 + 16'(2 * k + 1), 16'h1000 + 16'(2 * k)});
        chk("t3_consec", wcyc[k], wcyc[0] + k);
      end
    end

    // Fifth word dropped
    do_reset();
    fifo_full = 1;
    for (int i = 0; i < 10; i++) drive(1, 16'h2000 + 16'(i), 0);
    idle(3);
    chk("t4_ovf", {31'd0, overflow}, Stats ? 32'd1 : 32'd0);
    fifo_full = 0;
    idle(10);
    chk("t4_nwords", wlog.size(), 4);
    if (wlog.size() == 4) chk("t4_last", wlog[3], 32'h2007_2006);

    // Sample on the flush cycle completes the pair; no pad
    do_reset();
    drive(1, 16'h5555, 0);
    drive(1, 16'h6666, 1);
    idle(8);
    chk("t5_nwords", wlog.size(), 1);
    if (wlog.size() == 1) chk("t5_word", wlog[0], 32'h6666_5555);
    chk("t5_done", done_cnt, 1);

    // Reset mid-flush aborts everything
    do_reset();
    fifo_full = 1;
    for (int i = 0; i < 4; i++) drive(1, 16'h3000 + 16'(i), 0);
    drive(0, 16'h0, 1);
    idle(2);
    chk("t6_busy_pre", {31'd0, busy}, 32'd1);
    do_reset();
    fifo_full = 0;
    idle(10);
    chk("t6_nwords", wlog.size(), 0);
    chk("t6_done", done_cnt, 0);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) fifo_full = ~fifo_full;
      drive(($urandom_range(0, 9) < 7), 16'($urandom), ($urandom_range(0, 63) == 0));
    end
    fifo_full = 0;
    drive(0, 16'h0, 1);
    seen = 0;
    for (int i = 0; i < 60 && seen == 0; i++) begin
      idle(1);
      if (flush_done === 1'b1) seen = 1;
    end
    chk("rand_drain", seen, 1);
    idle(2);
    chk("rand_busy", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_packer.md
Name: result_packer

Overview:
- Sits between the engine result output (16-bit fp16 samples with a write strobe) and the 32-bit result FIFO that feeds the host pipe-out.
- Packs pairs of 16-bit results into 32-bit words, buffers them in a small queue against FIFO back-pressure, and pads/flushes an odd trailing sample at layer end.
- Replaces the direct 16-bit-into-32-bit FIFO write, which wastes the upper half of each word.

Parameters:
- DATA_W, 16, input sample width; fixed ratio OUT_W = 2*DATA_W
- OUT_W, 32, packed output word width
- QUEUE_DEPTH, 4, packed-word holding queue entries, power of two, >= 2
- CNT_W, 16, width of word_count

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  engine result strobe (engine output_en)
- in_data  in  DATA_W  engine result sample
- flush  in  1  single-cycle pulse at layer end (engine layer_finish rising edge)
- fifo_full  in  1  result FIFO programmable-full flag; must have >= 1 word headroom
- out_wr_en  out  1  result FIFO write enable, registered
- out_data  out  OUT_W  result FIFO write data, registered
- busy  out  1  any data held, queued, or in flight, or flush in progress
- flush_done  out  1  one-cycle pulse when flush has fully drained
- word_count  out  CNT_W  words written since reset, saturating
- overflow  out  1  sticky: a sample or word was dropped

Behaviour:
- Reset (async, rst=1): out_wr_en=0, out_data=0, flush_done=0, word_count=0, overflow=0, busy=0. Queue empty, half-held flag cleared, FSM=IDLE. A reset during a flush aborts it; no flush_done pulse.
- Lane order: first sample of a pair -> [15:0], second -> [31:16].
- Half register: on in_valid with no half held, store in_data and set held. On in_valid with half held, form {in_data, held_sample}, push it to the queue, and clear held.
- Queue push/pop rules:
  - Pop when the queue is non-empty and fifo_full=0.
  - Popped word is registered onto out_data with out_wr_en=1 on the next edge; otherwise out_wr_en=0 and out_data holds its last value.
  - Push into a full queue with no pop in the same cycle: word dropped, overflow<=1.
  - Push and pop in the same cycle on a full queue is legal; nothing is dropped.
- Latency: with the queue empty and fifo_full=0, a word completed in cycle N appears at out_wr_en in cycle N+2.
- FSM:
  - IDLE -> FLUSH on flush=1.
    - If in_valid is also high that cycle, the sample is taken first.
    - If a half remains held after that, push the pad word {16'h0000, held_sample} and clear held.
    - Flush with nothing held pushes nothing.
  - FLUSH: in_valid is ignored; each ignored sample sets overflow.
  - FLUSH -> IDLE when the queue is empty and out_wr_en=0 at that edge; flush_done=1 for exactly that one cycle.
  - flush while in FLUSH is ignored.
- word_count increments on each out_wr_en=1 and saturates at all-ones.
- busy = held | queue non-empty | out_wr_en | (state==FLUSH).
- Pointers wrap modulo QUEUE_DEPTH. Occupancy is tracked with one extra bit so full and empty are distinct.

Optional Feature:
- Macro: RESULT_PACK_STATS_EN.
- Defined: word_count and overflow behave as above.
- Undefined: the counter and sticky logic are not built; word_count=0 and overflow=0 constantly. Drop behaviour on overflow is unchanged.

Test Plan:
- Samples 0x1111, 0x2222 on consecutive cycles, fifo_full=0 -> out_wr_en pulses once, out_data=0x2222_1111, two cycles after 0x2222; word_count=1.
- Three samples 0xA, 0xB, 0xC, then flush -> words 0x000B_000A and 0x0000_000C written; flush_done single pulse after the second write; busy=0 afterwards.
- fifo_full=1, eight back-to-back samples (QUEUE_DEPTH=4) -> no writes while full, overflow=0. Release fifo_full -> four words drained on consecutive cycles in order.
- fifo_full=1, ten samples -> fifth word dropped, overflow=1. Release -> exactly four words written.
- Held 0x5555, then in_valid=1 with 0x6666 in the same cycle as flush -> single word 0x6666_5555, no pad word, then flush_done.
- rst asserted mid-flush with two words queued -> all outputs 0 immediately, no flush_done, no further writes after release.
